// File: rtl/sp_operand_loader.sv
// sp_operand_loader: stages a 13-beat tile into the A/B/C/widx operand buses of the
// 4-octet sparse tensor core and sequences its start / fetch_done / write_back handshake.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   clear               synchronous abort back to LOAD (tile_cnt kept)
//   in_valid/in_ready   stream handshake, in_data one beat per accept
//   core_idle/fetch/wb  AND-reduced status flags from the core octets
//   core_start          one-cycle start pulse
//   core_fetch_done     one-cycle fetch_done pulse
//   a/b/c_data_out      packed operands, octet k at [k*DATA_WIDTH +: DATA_WIDTH]
//   widx_out            weight indices, octet k at [k*32 +: 32]
//   busy                state != LOAD
//   tile_done, tile_cnt completion pulse and wrapping completed-tile count

module sp_operand_loader #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    core_idle,
    input  logic                    core_fetch,
    input  logic                    core_write_back,
    output logic                    core_start,
    output logic                    core_fetch_done,
    output logic [4*DATA_WIDTH-1:0] a_data_out,
    output logic [4*DATA_WIDTH-1:0] b_data_out,
    output logic [4*DATA_WIDTH-1:0] c_data_out,
    output logic [127:0]            widx_out,
    output logic                    busy,
    output logic                    tile_done,
    output logic [CNT_WIDTH-1:0]    tile_cnt
);

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        FETCH,
        RUN
    } state_t;

    state_t                  state_q;
    logic [3:0]              beat_cnt_q;
    logic                    seen_wb_q;
    logic [4*DATA_WIDTH-1:0] a_q;
    logic [4*DATA_WIDTH-1:0] b_q;
    logic [4*DATA_WIDTH-1:0] c_q;
    logic [127:0]            widx_q;
    logic                    start_q;
    logic                    fdone_q;
    logic                    tdone_q;
    logic [CNT_WIDTH-1:0]    tile_cnt_q;

    logic [127:0]            beat_idx;
    logic [3:0]              c_off;
    logic [1:0]              ab_slot;
    logic [1:0]              c_slot;

    // Index beat is exactly 128 bits regardless of the stream width.
    generate
        if (DATA_WIDTH >= 128) begin : g_idx_trunc
            assign beat_idx = in_data[127:0];
        end else begin : g_idx_ext
            assign beat_idx = {{(128-DATA_WIDTH){1'b0}}, in_data};
        end
    endgenerate

    // C beats occupy positions 9..12, so rebase them to slot 0..3.
    assign c_off   = beat_cnt_q - 4'd9;
    assign ab_slot = beat_cnt_q[1:0];
    assign c_slot  = c_off[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= LOAD;
            beat_cnt_q <= '0;
            seen_wb_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            widx_q     <= '0;
            start_q    <= 1'b0;
            fdone_q    <= 1'b0;
            tdone_q    <= 1'b0;
            tile_cnt_q <= '0;
        end else begin
            start_q <= 1'b0;
            fdone_q <= 1'b0;
            tdone_q <= 1'b0;
            if (clear) begin
                state_q    <= LOAD;
                beat_cnt_q <= '0;
                seen_wb_q  <= 1'b0;
                a_q        <= '0;
                b_q        <= '0;
                c_q        <= '0;
                widx_q     <= '0;
            end else begin
                unique case (state_q)
                    LOAD: begin
                        if (in_valid) begin
                            if (beat_cnt_q < 4'd4) begin
                                a_q[int'(ab_slot)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                            end else if (beat_cnt_q < 4'd8) begin
                                b_q[int'(ab_slot)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                            end else if (beat_cnt_q == 4'd8) begin
                                widx_q <= beat_idx;
                            end else begin
                                c_q[int'(c_slot)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                            end
                            if (beat_cnt_q == 4'd12) begin
                                beat_cnt_q <= '0;
                                state_q    <= ISSUE;
                            end else begin
                                beat_cnt_q <= beat_cnt_q + 4'd1;
                            end
                        end
                    end
                    ISSUE: begin
                        if (core_idle) begin
                            start_q <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (core_fetch) begin
                            fdone_q <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        // Registered seen_wb keeps idle-before-write_back from exiting.
                        if (seen_wb_q && core_idle) begin
                            tdone_q    <= 1'b1;
                            tile_cnt_q <= tile_cnt_q + CNT_WIDTH'(1);
                            seen_wb_q  <= 1'b0;
                            state_q    <= LOAD;
                        end else if (core_write_back) begin
                            seen_wb_q <= 1'b1;
                        end
                    end
                    default: state_q <= LOAD;
                endcase
            end
        end
    end

    assign in_ready        = (state_q == LOAD);
    assign busy            = (state_q != LOAD);
    assign core_start      = start_q;
    assign core_fetch_done = fdone_q;
    assign tile_done       = tdone_q;
    assign tile_cnt        = tile_cnt_q;
    assign a_data_out      = a_q;
    assign b_data_out      = b_q;
    assign c_data_out      = c_q;
    assign widx_out        = widx_q;

endmodule

// File: tb/tb_sp_operand_loader.sv
// tb_sp_operand_loader: scoreboard bench for sp_operand_loader.
// Expected tiles are queued as beats are sent and compared when core_start fires.

module tb_sp_operand_loader;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          core_idle = 1'b0;
    logic          core_fetch = 1'b0;
    logic          core_write_back = 1'b0;
    logic          core_start;
    logic          core_fetch_done;
    logic [4*DW-1:0] a_data_out;
    logic [4*DW-1:0] b_data_out;
    logic [4*DW-1:0] c_data_out;
    logic [127:0]  widx_out;
    logic          busy;
    logic          tile_done;
    logic [15:0]   tile_cnt;

    sp_operand_loader #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .rstn(rstn),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .core_idle(core_idle),
        .core_fetch(core_fetch),
        .core_write_back(core_write_back),
        .core_start(core_start),
        .core_fetch_done(core_fetch_done),
        .a_data_out(a_data_out),
        .b_data_out(b_data_out),
        .c_data_out(c_data_out),
        .widx_out(widx_out),
        .busy(busy),
        .tile_done(tile_done),
        .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*DW-1:0] a;
        logic [4*DW-1:0] b;
        logic [4*DW-1:0] c;
        logic [127:0]    w;
    } tile_t;

    tile_t       sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_start = 0;
    logic [15:0] exp_cnt = '0;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn && core_start) begin
            tile_t e;
            n_start++;
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("a_ops", a_data_out, e.a);
                chk("b_ops", b_data_out, e.b);
                chk("c_ops", c_data_out, e.c);
                chk("widx", widx_out, e.w);
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input bit rnd);
        int  n;
        bit  acc;
        n = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1 && n < 8) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                tick();
                n++;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("beat_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_tile(input logic [DW-1:0] bt[13], input bit rnd);
        tile_t e;
        for (int i = 0; i < 13; i++) send_beat(bt[i], rnd);
        for (int k = 0; k < 4; k++) begin
            e.a[k*DW +: DW] = bt[k];
            e.b[k*DW +: DW] = bt[4+k];
            e.c[k*DW +: DW] = bt[9+k];
        end
        e.w = bt[8];
        sb.push_back(e);
    endtask

    task automatic run_tile();
        int n;
        n = 0;
        core_idle = 1'b1;
        while (!core_start && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", core_start, 1);
        core_idle  = 1'b0;
        core_fetch = 1'b1;
        tick();
        chk("fetch_done", core_fetch_done, 1);
        core_fetch      = 1'b0;
        core_write_back = 1'b1;
        tick();
        core_write_back = 1'b0;
        core_idle       = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("tile_done", tile_done, 1);
        chk("tile_cnt", tile_cnt, exp_cnt);
    endtask

    logic [DW-1:0] bt[13];
    int            s0;

    initial begin
        #2;
        chk("rst_start", core_start, 0);
        chk("rst_a", a_data_out, 0);
        chk("rst_cnt", tile_cnt, 0);
        chk("rst_busy", busy, 0);
        #10;
        rstn = 1'b1;
        tick();
        chk("rdy_after_rst", in_ready, 1);

        // tile 1: beats are their own index
        core_idle = 1'b1;
        for (int i = 0; i < 13; i++) bt[i] = DW'(i);
        send_tile(bt, 1'b0);
        chk("rdy_low", in_ready, 0);
        chk("busy_issue", busy, 1);
        chk("start_early", core_start, 0);
        chk("w_is_8", widx_out, 128'd8);
        tick();
        chk("start_min_lat", core_start, 1);
        tick();
        chk("start_one", core_start, 0);
        core_idle  = 1'b0;
        core_fetch = 1'b1;
        tick();
        chk("fdone1", core_fetch_done, 1);
        core_fetch = 1'b0;
        core_idle  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("run_hold_busy", busy, 1);
            chk("run_no_done", tile_done, 0);
        end
        core_write_back = 1'b1;
        tick();
        core_write_back = 1'b0;
        chk("wb_edge_no_done", tile_done, 0);
        tick();
        exp_cnt = 16'd1;
        chk("done1", tile_done, 1);
        chk("cnt1", tile_cnt, exp_cnt);
        chk("rdy_after_done", in_ready, 1);
        tick();
        chk("done_one", tile_done, 0);

        // tile 2: core stays busy in ISSUE
        core_idle = 1'b0;
        for (int i = 0; i < 13; i++) bt[i] = DW'(100 + i);
        send_tile(bt, 1'b0);
        s0 = n_start;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("issue_wait", core_start, 0);
            chk("issue_busy", busy, 1);
        end
        core_idle = 1'b1;
        tick();
        chk("start2", core_start, 1);
        core_idle = 1'b0;
        tick();
        chk("start2_one", core_start, 0);
        chk("start2_cnt", n_start, s0 + 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fetch_wait", core_fetch_done, 0);
            chk("fetch_busy", busy, 1);
        end
        core_fetch = 1'b1;
        tick();
        chk("fdone2", core_fetch_done, 1);
        core_fetch      = 1'b0;
        core_write_back = 1'b1;
        tick();
        core_write_back = 1'b0;
        chk("fdone2_one", core_fetch_done, 0);
        core_idle = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("done2", tile_done, 1);
        chk("cnt2", tile_cnt, exp_cnt);

        // three tiles with random valid gaps
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 13; i++)
                bt[i] = {$urandom, $urandom, $urandom, $urandom};
            send_tile(bt, 1'b1);
            run_tile();
        end
        chk("cnt_after_rand", tile_cnt, 16'd5);

        // clear after 6 beats discards the partial tile
        core_idle = 1'b0;
        for (int i = 0; i < 6; i++) send_beat(DW'(200 + i), 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(777);
        #1;
        chk("rdy_in_clear", in_ready, 1);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_a", a_data_out, 0);
        chk("clr_b", b_data_out, 0);
        chk("clr_busy", busy, 0);
        chk("clr_cnt_kept", tile_cnt, exp_cnt);
        for (int i = 0; i < 13; i++) bt[i] = DW'(300 + i);
        send_tile(bt, 1'b0);
        run_tile();

        // wrap from all-ones
        force dut.tile_cnt_q = 16'hFFFF;
        #1;
        release dut.tile_cnt_q;
        exp_cnt = 16'hFFFF;
        chk("cnt_forced", tile_cnt, exp_cnt);
        for (int i = 0; i < 13; i++) bt[i] = DW'(400 + i);
        send_tile(bt, 1'b0);
        run_tile();
        chk("cnt_wrap", tile_cnt, 16'd0);

        // async reset while in RUN
        for (int i = 0; i < 13; i++) bt[i] = DW'(500 + i);
        send_tile(bt, 1'b0);
        core_idle = 1'b1;
        tick();
        core_idle  = 1'b0;
        core_fetch = 1'b1;
        tick();
        core_fetch = 1'b0;
        tick();
        chk("pre_rst_busy", busy, 1);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_a", a_data_out, 0);
        chk("arst_c", c_data_out, 0);
        chk("arst_w", widx_out, 0);
        chk("arst_cnt", tile_cnt, 0);
        chk("arst_fd", core_fetch_done, 0);
        chk("sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
